// File: rtl/grid_map_server_pkg.sv
// Shared constants and emitter state type for the grid map server.
package grid_map_server_pkg;
  localparam logic [3:0]  MAP_DIM     = 4'd8;
  localparam logic [9:0]  X_ORIGIN    = 10'd80;
  localparam logic [9:0]  Y_ORIGIN    = 10'd0;
  localparam logic [9:0]  CELL_SIZE   = 10'd60;
  localparam logic [63:0] DEFAULT_MAP = 64'hFF81A1A585A5A1FF;

  typedef enum logic {ST_IDLE, ST_EMIT} emit_state_t;
endpackage

// File: rtl/grid_tile_emitter.sv
// Walks the 8x8 map in row-major order and streams each tile's pixel origin and wall bit.
module grid_tile_emitter
  import grid_map_server_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       emit_start,
  input  logic       t_ready,
  input  logic       map_bit,
  output logic [5:0] map_idx,
  output logic       emit_busy,
  output logic       t_valid,
  output logic       t_last,
  output logic       t_wall,
  output logic [9:0] t_x,
  output logic [9:0] t_y
);
  emit_state_t state, state_next;
  logic [5:0]  idx, idx_next;
  logic [9:0]  x_next, y_next;
  logic        wall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      t_x    <= X_ORIGIN;
      t_y    <= Y_ORIGIN;
      t_wall <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      t_x    <= x_next;
      t_y    <= y_next;
      t_wall <= wall_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    x_next     = t_x;
    y_next     = t_y;
    wall_next  = t_wall;
    map_idx    = idx + 6'd1;
    emit_busy  = (state == ST_EMIT);
    t_valid    = (state == ST_EMIT);
    t_last     = (state == ST_EMIT) && (idx == 6'd63);
    case (state)
      ST_IDLE: begin
        map_idx = '0;
        if (emit_start) begin
          state_next = ST_EMIT;
          idx_next   = '0;
          x_next     = X_ORIGIN;
          y_next     = Y_ORIGIN;
          wall_next  = map_bit;
        end
      end
      ST_EMIT: begin
        if (t_ready) begin
          if (idx == 6'd63) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            x_next     = X_ORIGIN;
            y_next     = Y_ORIGIN;
            wall_next  = 1'b0;
          end else begin
            idx_next  = idx + 6'd1;
            wall_next = map_bit;
            // Coordinates step by accumulation; column wrap restarts x and advances y.
            if (idx[2:0] == 3'd7) begin
              x_next = X_ORIGIN;
              y_next = t_y + CELL_SIZE;
            end else begin
              x_next = t_x + CELL_SIZE;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/grid_map_server.sv
// Owns the 8x8 wall map: answers cell queries and streams tiles to the overlay.
// GRID_MAP_WRITE_EN adds the w_* write port; otherwise the map is the constant DEFAULT_MAP.
module grid_map_server
  import grid_map_server_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic [3:0] q_cx,
  input  logic [3:0] q_cy,
  output logic       r_valid,
  input  logic       r_ready,
  output logic       r_wall,
  input  logic       emit_start,
  output logic       emit_busy,
  output logic       t_valid,
  input  logic       t_ready,
  output logic [9:0] t_x,
  output logic [9:0] t_y,
  output logic       t_wall,
  output logic       t_last
`ifdef GRID_MAP_WRITE_EN
  ,
  input  logic       w_en,
  input  logic [2:0] w_cx,
  input  logic [2:0] w_cy,
  input  logic       w_wall
`endif
);
  logic [63:0] map;
  logic [5:0]  tile_idx;
  logic        out_range;

`ifdef GRID_MAP_WRITE_EN
  always_ff @(posedge clk) begin
    if (rst)
      map <= DEFAULT_MAP;
    else if (w_en)
      map[{w_cy, w_cx}] <= w_wall;
  end
`else
  always_comb map = DEFAULT_MAP;
`endif

  assign q_ready   = !r_valid || r_ready;
  assign out_range = (q_cx >= MAP_DIM) || (q_cy >= MAP_DIM);

  // Reads the pre-edge map, so a same-cycle write is not visible to the query.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wall  <= 1'b0;
    end else if (q_valid && q_ready) begin
      r_valid <= 1'b1;
      r_wall  <= out_range ? 1'b1 : map[{q_cy[2:0], q_cx[2:0]}];
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

  grid_tile_emitter u_emitter (
    .clk        (clk),
    .rst        (rst),
    .emit_start (emit_start),
    .t_ready    (t_ready),
    .map_bit    (map[tile_idx]),
    .map_idx    (tile_idx),
    .emit_busy  (emit_busy),
    .t_valid    (t_valid),
    .t_last     (t_last),
    .t_wall     (t_wall),
    .t_x        (t_x),
    .t_y        (t_y)
  );
endmodule

// File: tb/tb_grid_map_server.sv
// Directed self-checking bench for grid_map_server (write tests need GRID_MAP_WRITE_EN).
module tb_grid_map_server;
  logic       clk = 1'b0;
  logic       rst, q_valid, r_ready, emit_start, t_ready;
  logic [3:0] q_cx, q_cy;
  logic       q_ready, r_valid, r_wall, emit_busy, t_valid, t_wall, t_last;
  logic [9:0] t_x, t_y;
`ifdef GRID_MAP_WRITE_EN
  logic       w_en, w_wall;
  logic [2:0] w_cx, w_cy;
`endif

  logic [63:0] dmap = 64'hFF81A1A585A5A1FF;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  grid_map_server dut (
    .clk        (clk),
    .rst        (rst),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_cx       (q_cx),
    .q_cy       (q_cy),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_wall     (r_wall),
    .emit_start (emit_start),
    .emit_busy  (emit_busy),
    .t_valid    (t_valid),
    .t_ready    (t_ready),
    .t_x        (t_x),
    .t_y        (t_y),
    .t_wall     (t_wall),
    .t_last     (t_last)
`ifdef GRID_MAP_WRITE_EN
    ,
    .w_en       (w_en),
    .w_cx       (w_cx),
    .w_cy       (w_cy),
    .w_wall     (w_wall)
`endif
  );

  task test_reset;
    rst = 1'b1; q_valid = 1'b0; q_cx = '0; q_cy = '0; r_ready = 1'b1;
    emit_start = 1'b0; t_ready = 1'b0;
`ifdef GRID_MAP_WRITE_EN
    w_en = 1'b0; w_cx = '0; w_cy = '0; w_wall = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (q_ready !== 1'b1) begin fails++; $display("FAIL reset_q_ready: got %b expected 1", q_ready); end
    checks++; if (r_valid !== 1'b0) begin fails++; $display("FAIL reset_r_valid: got %b expected 0", r_valid); end
    checks++; if (r_wall !== 1'b0) begin fails++; $display("FAIL reset_r_wall: got %b expected 0", r_wall); end
    checks++; if (emit_busy !== 1'b0) begin fails++; $display("FAIL reset_emit_busy: got %b expected 0", emit_busy); end
    checks++; if (t_valid !== 1'b0) begin fails++; $display("FAIL reset_t_valid: got %b expected 0", t_valid); end
    checks++; if (t_last !== 1'b0) begin fails++; $display("FAIL reset_t_last: got %b expected 0", t_last); end
    checks++; if (t_wall !== 1'b0) begin fails++; $display("FAIL reset_t_wall: got %b expected 0", t_wall); end
    checks++; if (t_x !== 10'd80) begin fails++; $display("FAIL reset_t_x: got %0d expected 80", t_x); end
    checks++; if (t_y !== 10'd0) begin fails++; $display("FAIL reset_t_y: got %0d expected 0", t_y); end
    rst = 1'b0;
  endtask

  task test_query;
    logic [3:0] cx [5] = '{4'd0, 4'd2, 4'd5, 4'd8, 4'd3};
    logic [3:0] cy [5] = '{4'd0, 4'd1, 4'd1, 4'd3, 4'd15};
    logic       ew [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      q_valid = 1'b1; q_cx = cx[i]; q_cy = cy[i];
      checks++; if (q_ready !== 1'b1) begin fails++; $display("FAIL query_ready[%0d]: got %b expected 1", i, q_ready); end
      @(negedge clk);
      q_valid = 1'b0;
      checks++; if (r_valid !== 1'b1) begin fails++; $display("FAIL query_valid[%0d]: got %b expected 1", i, r_valid); end
      checks++; if (r_wall !== ew[i]) begin fails++; $display("FAIL query_wall(%0d,%0d): got %b expected %b", cx[i], cy[i], r_wall, ew[i]); end
    end
    @(negedge clk);
    checks++; if (r_valid !== 1'b0) begin fails++; $display("FAIL query_drain: got %b expected 0", r_valid); end
  endtask

  task test_back_to_back;
    logic [3:0] cx [4] = '{4'd1, 4'd0, 4'd7, 4'd6};
    logic       ew [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    q_valid = 1'b1; q_cx = cx[0]; q_cy = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (r_valid !== 1'b1 || r_wall !== ew[i]) begin
        fails++; $display("FAIL b2b[%0d]: got valid %b wall %b expected valid 1 wall %b", i, r_valid, r_wall, ew[i]);
      end
      if (i < 3) q_cx = cx[i+1];
      else q_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task test_backpressure;
    r_ready = 1'b0;
    @(negedge clk);
    q_valid = 1'b1; q_cx = 4'd0; q_cy = 4'd0;
    @(negedge clk);
    q_cx = 4'd2; q_cy = 4'd1;
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b1) begin fails++; $display("FAIL bp_first: got valid %b wall %b expected 1 1", r_valid, r_wall); end
    checks++; if (q_ready !== 1'b0) begin fails++; $display("FAIL bp_q_ready: got %b expected 0", q_ready); end
    @(negedge clk);
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b1) begin fails++; $display("FAIL bp_hold: got valid %b wall %b expected 1 1", r_valid, r_wall); end
    checks++; if (q_ready !== 1'b0) begin fails++; $display("FAIL bp_q_ready_hold: got %b expected 0", q_ready); end
    r_ready = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b0) begin fails++; $display("FAIL bp_second: got valid %b wall %b expected 1 0", r_valid, r_wall); end
    @(negedge clk);
    checks++; if (r_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", r_valid); end
  endtask

  task test_emit;
    int hs, cyc;
    logic [9:0] ex, ey;
    t_ready = 1'b1;
    @(negedge clk); emit_start = 1'b1;
    @(negedge clk); emit_start = 1'b0;
    checks++; if (t_valid !== 1'b1) begin fails++; $display("FAIL emit_first_valid: got %b expected 1", t_valid); end
    hs = 0; cyc = 0;
    while (t_valid === 1'b1 && cyc < 100) begin
      ex = 10'(80 + 60 * (hs % 8));
      ey = 10'(60 * (hs / 8));
      checks++; if (t_x !== ex || t_y !== ey || t_wall !== dmap[hs] || t_last !== (hs == 63) || emit_busy !== 1'b1) begin
        fails++; $display("FAIL tile[%0d]: got (%0d,%0d,w%b,l%b,b%b) expected (%0d,%0d,w%b,l%b,b1)",
                          hs, t_x, t_y, t_wall, t_last, emit_busy, ex, ey, dmap[hs], (hs == 63));
      end
      if (hs == 0) begin checks++; if (t_x !== 10'd80 || t_y !== 10'd0 || t_wall !== 1'b1) begin fails++; $display("FAIL tile0_vec: got (%0d,%0d,%b) expected (80,0,1)", t_x, t_y, t_wall); end end
      if (hs == 9) begin checks++; if (t_x !== 10'd140 || t_y !== 10'd60 || t_wall !== 1'b0) begin fails++; $display("FAIL tile9_vec: got (%0d,%0d,%b) expected (140,60,0)", t_x, t_y, t_wall); end end
      if (hs == 63) begin checks++; if (t_x !== 10'd500 || t_y !== 10'd420 || t_wall !== 1'b1 || t_last !== 1'b1) begin fails++; $display("FAIL tile63_vec: got (%0d,%0d,%b,%b) expected (500,420,1,1)", t_x, t_y, t_wall, t_last); end end
      emit_start = (hs == 5);
      hs++; cyc++;
      @(negedge clk);
    end
    emit_start = 1'b0;
    checks++; if (hs != 64) begin fails++; $display("FAIL emit_handshakes: got %0d expected 64", hs); end
    checks++; if (emit_busy !== 1'b0 || t_valid !== 1'b0) begin fails++; $display("FAIL emit_done: got busy %b valid %b expected 0 0", emit_busy, t_valid); end
    t_ready = 1'b0;
  endtask

`ifdef GRID_MAP_WRITE_EN
  task test_write;
    @(negedge clk); w_en = 1'b1; w_cx = 3'd2; w_cy = 3'd1; w_wall = 1'b1;
    @(negedge clk); w_en = 1'b0;
    q_valid = 1'b1; q_cx = 4'd2; q_cy = 4'd1;
    @(negedge clk); q_valid = 1'b0;
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b1) begin fails++; $display("FAIL write_2_1: got valid %b wall %b expected 1 1", r_valid, r_wall); end
    w_en = 1'b1; w_cx = 3'd3; w_cy = 3'd2; w_wall = 1'b1;
    @(negedge clk);
    w_wall = 1'b0; q_valid = 1'b1; q_cx = 4'd3; q_cy = 4'd2;
    @(negedge clk); w_en = 1'b0; q_valid = 1'b0;
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b1) begin fails++; $display("FAIL write_same_cycle: got valid %b wall %b expected 1 1", r_valid, r_wall); end
    q_valid = 1'b1;
    @(negedge clk); q_valid = 1'b0;
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b0) begin fails++; $display("FAIL write_after: got valid %b wall %b expected 1 0", r_valid, r_wall); end
    @(negedge clk);
  endtask
`endif

  task test_reset_midstream;
    int hs, cyc;
    r_ready = 1'b0; t_ready = 1'b0;
    @(negedge clk); q_valid = 1'b1; q_cx = 4'd0; q_cy = 4'd0;
    @(negedge clk); q_valid = 1'b0; emit_start = 1'b1;
    @(negedge clk); emit_start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 20 && cyc < 200) begin
      t_ready = ~t_ready;
      if (t_valid === 1'b1 && t_ready === 1'b1) hs++;
      cyc++;
      @(negedge clk);
    end
    t_ready = 1'b0;
    checks++; if (hs != 20) begin fails++; $display("FAIL mid_reach_tile20: got %0d expected 20", hs); end
    checks++; if (t_valid !== 1'b1 || t_x !== 10'd320 || t_y !== 10'd120) begin fails++; $display("FAIL mid_tile20: got (v%b,%0d,%0d) expected (v1,320,120)", t_valid, t_x, t_y); end
    checks++; if (r_valid !== 1'b1) begin fails++; $display("FAIL mid_resp_pending: got %b expected 1", r_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (t_valid !== 1'b0 || emit_busy !== 1'b0 || t_last !== 1'b0 || t_wall !== 1'b0) begin
      fails++; $display("FAIL mid_rst_stream: got valid %b busy %b last %b wall %b expected 0 0 0 0", t_valid, emit_busy, t_last, t_wall);
    end
    checks++; if (t_x !== 10'd80 || t_y !== 10'd0) begin fails++; $display("FAIL mid_rst_xy: got (%0d,%0d) expected (80,0)", t_x, t_y); end
    checks++; if (r_valid !== 1'b0 || r_wall !== 1'b0 || q_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_query: got valid %b wall %b ready %b expected 0 0 1", r_valid, r_wall, q_ready); end
    rst = 1'b0; r_ready = 1'b1;
    @(negedge clk); q_valid = 1'b1; q_cx = 4'd2; q_cy = 4'd1;
    @(negedge clk); q_valid = 1'b0;
    checks++; if (r_valid !== 1'b1 || r_wall !== 1'b0) begin fails++; $display("FAIL mid_map_default: got valid %b wall %b expected 1 0", r_valid, r_wall); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_query();
    test_back_to_back();
    test_backpressure();
    test_emit();
`ifdef GRID_MAP_WRITE_EN
    test_write();
`endif
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
